// File: rtl/branch_pkg.sv
// Shared opcode and comparator encodings for the branch-resolution stage.
package branch_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_BEQ  = 3'd1;
  localparam logic [2:0] OP_BNE  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;
  localparam logic [2:0] OP_BGT  = 3'd4;
  localparam logic [2:0] OP_BLE  = 3'd5;
  localparam logic [2:0] OP_BGE  = 3'd6;
  localparam logic [2:0] OP_JUMP = 3'd7;

  // Must match the 32-bit comparator's output encoding exactly.
  localparam logic [1:0] CMP_EQ  = 2'd0;
  localparam logic [1:0] CMP_LT  = 2'd1;
  localparam logic [1:0] CMP_GT  = 2'd2;
  localparam logic [1:0] CMP_BAD = 2'd3;

  typedef struct packed {
    logic        taken;
    logic [31:0] redirect_pc;
    logic        mispredict;
  } br_result_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolution: taken decode, redirect PC, mispredict flag and statistics,
// behind a one-deep valid/ready output register.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_cmp,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [31:0]      out_redirect_pc,
  output logic             out_mispredict,
  output logic             cmp_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  function automatic logic branch_taken(input logic [2:0] op, input logic [1:0] cmp);
    logic eq, lt, gt, tk;
    eq = (cmp == CMP_EQ);
    lt = (cmp == CMP_LT);
    gt = (cmp == CMP_GT);
    unique case (op)
      OP_NOP:  tk = 1'b0;
      OP_BEQ:  tk = eq;
      OP_BNE:  tk = lt | gt;
      OP_BLT:  tk = lt;
      OP_BGT:  tk = gt;
      OP_BLE:  tk = eq | lt;
      OP_BGE:  tk = eq | gt;
      OP_JUMP: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

  logic       valid_q, valid_d;
  br_result_t res_q, res_d;
  logic       cmp_err_q, cmp_err_d;
  logic       accept, handshake, cmp_bad;
  logic [31:0] fall_through;

  assign in_ready  = !valid_q || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  assign handshake = valid_q && out_ready && !flush;
  assign cmp_bad   = (in_cmp == CMP_BAD) && (in_op != OP_NOP) && (in_op != OP_JUMP);

  always_comb begin
    fall_through      = in_pc + 32'd1;
    res_d.taken       = branch_taken(in_op, in_cmp);
    res_d.redirect_pc = fall_through;
    if (res_d.taken) begin
      res_d.redirect_pc = (in_op == OP_JUMP) ? in_imm : fall_through + in_imm;
    end
    res_d.mispredict = res_d.taken != in_pred_taken;

    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end

    cmp_err_d = cmp_err_q | (accept & cmp_bad);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      res_q     <= '0;
      cmp_err_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      cmp_err_q <= cmp_err_d;
      if (accept) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid       = valid_q;
  assign out_taken       = res_q.taken;
  assign out_redirect_pc = res_q.redirect_pc;
  assign out_mispredict  = res_q.mispredict;
  assign cmp_err         = cmp_err_q;

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (handshake),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (handshake && res_q.mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench: vector table, hand sequences, random scoreboard, saturation.
module tb_branch_resolver;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, in_pred_taken;
  logic [2:0]  in_op;
  logic [1:0]  in_cmp;
  logic [31:0] in_pc, in_imm, out_redirect_pc;
  logic        out_valid, out_ready, out_taken, out_mispredict, cmp_err;
  logic [15:0] branch_count, mispredict_count;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_taken, s_out_mispredict, s_cmp_err;
  logic [31:0] s_out_redirect_pc;
  logic [3:0]  s_branch_count, s_mispredict_count;

  always #5 clock = ~clock;

  branch_resolver #(.CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cmp(in_cmp),
    .in_pc(in_pc), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
    .out_redirect_pc(out_redirect_pc), .out_mispredict(out_mispredict),
    .cmp_err(cmp_err), .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_resolver #(.CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(3'd7), .in_cmp(2'd0),
    .in_pc(32'h10), .in_imm(32'h0000_0ABC), .in_pred_taken(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_taken(s_out_taken),
    .out_redirect_pc(s_out_redirect_pc), .out_mispredict(s_out_mispredict),
    .cmp_err(s_cmp_err), .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  cmp;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        pred;
    logic        taken;
    logic [31:0] redirect;
    logic        mis;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] redirect;
    logic        mis;
  } res_t;

  int   total = 0;
  int   bad = 0;
  int   exp_b, exp_m, nmis, h;
  logic exp_err, exp_rdy, hs, t;
  vec_t vecs[$];
  vec_t v;
  res_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [2:0] op, input logic [1:0] cmp,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    in_valid = vld; in_op = op; in_cmp = cmp; in_pc = pc; in_imm = imm; in_pred_taken = pred;
  endtask

  // Taken rule straight from the opcode table, phrased as relations.
  function automatic logic ref_taken(input int op, input int cmp);
    bit eq = (cmp == 0), lt = (cmp == 1), gt = (cmp == 2);
    case (op)
      1: return eq;
      2: return lt || gt;
      3: return lt;
      4: return gt;
      5: return eq || lt;
      6: return eq || gt;
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_redirect(input int op, input logic [31:0] pc,
                                               input logic [31:0] imm, input logic tk);
    if (!tk) return pc + 32'd1;
    if (op == 7) return imm;
    return pc + 32'd1 + imm;
  endfunction

  function automatic int sat_inc(input int c, input int maxv);
    return (c < maxv) ? c + 1 : c;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; s_in_valid = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", out_taken, 0);
    chk("rst_redirect", out_redirect_pc, 0);
    chk("rst_mispredict", out_mispredict, 0);
    chk("rst_cmp_err", cmp_err, 0);
    chk("rst_branch_count", branch_count, 0);
    chk("rst_mis_count", mispredict_count, 0);
    @(posedge clock); #1 reset = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // ---- table-driven vectors, streamed back to back ----
    vecs.push_back('{3'd1, 2'd0, 32'h100, 32'h10, 1'b0, 1'b1, 32'h111, 1'b1});
    vecs.push_back('{3'd2, 2'd2, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1});
    vecs.push_back('{3'd7, 2'd0, 32'h1234, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{3'd7, 2'd3, 32'h40, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0});
    vecs.push_back('{3'd0, 2'd3, 32'h40, 32'h80, 1'b0, 1'b0, 32'h41, 1'b0});
    vecs.push_back('{3'd4, 2'd1, 32'h5, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h6, 1'b1});
    vecs.push_back('{3'd6, 2'd2, 32'h20, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h11, 1'b1});
    for (int op = 0; op < 8; op++) begin
      for (int c = 0; c < 3; c++) begin
        v.op = 3'(op); v.cmp = 2'(c); v.pc = $urandom; v.imm = $urandom; v.pred = 1'b1;
        v.taken = ref_taken(op, c);
        v.redirect = ref_redirect(op, v.pc, v.imm, v.taken);
        v.mis = !v.taken;
        vecs.push_back(v);
      end
    end
    nmis = 0;
    foreach (vecs[i]) if (vecs[i].mis) nmis++;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].cmp, vecs[i].pc, vecs[i].imm, vecs[i].pred);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_taken", i), out_taken, vecs[i].taken);
      chk($sformatf("vec%0d_redirect", i), out_redirect_pc, vecs[i].redirect);
      chk($sformatf("vec%0d_mispredict", i), out_mispredict, vecs[i].mis);
      if (i == 0) chk("first_count_before_hs", branch_count, 0);
      if (i == 1) chk("first_count_after_hs", branch_count, 1);
      if (i == 1) chk("first_mis_after_hs", mispredict_count, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("table_drain_valid", out_valid, 0);
    exp_b = vecs.size();
    exp_m = nmis;
    chk("table_branch_count", branch_count, exp_b);
    chk("table_mis_count", mispredict_count, exp_m);
    chk("table_cmp_err", cmp_err, 0);

    // ---- backpressure ----
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 2'd0, 32'h200, 32'h4, 1'b1);
    tick();
    chk("bp_a_valid", out_valid, 1);
    chk("bp_a_redirect", out_redirect_pc, 32'h205);
    drive(1'b1, 3'd3, 2'd2, 32'h300, 32'h8, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_in_ready_low", in_ready, 0);
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_redirect", out_redirect_pc, 32'h205);
      chk("bp_hold_taken", out_taken, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    tick();
    chk("bp_b_valid", out_valid, 1);
    chk("bp_b_redirect", out_redirect_pc, 32'h301);
    chk("bp_b_taken", out_taken, 0);
    chk("bp_b_mispredict", out_mispredict, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain_valid", out_valid, 0);
    exp_b += 2; exp_m += 1;
    chk("bp_branch_count", branch_count, exp_b);
    chk("bp_mis_count", mispredict_count, exp_m);

    // ---- flush with held result and new input ----
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 2'd1, 32'h400, 32'h4, 1'b0);
    tick();
    chk("fl_held_valid", out_valid, 1);
    drive(1'b1, 3'd1, 2'd0, 32'h480, 32'h4, 1'b0);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid_cleared", out_valid, 0);
    tick();
    chk("fl_input_dropped", out_valid, 0);
    chk("fl_branch_count", branch_count, exp_b);
    chk("fl_mis_count", mispredict_count, exp_m);

    // ---- illegal comparator code ----
    drive(1'b1, 3'd3, 2'd3, 32'h500, 32'h10, 1'b1);
    tick();
    chk("err_taken", out_taken, 0);
    chk("err_redirect", out_redirect_pc, 32'h501);
    chk("err_cmp_err", cmp_err, 1);
    in_valid = 1'b0;
    tick();
    exp_b++; exp_m++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("err_sticky", cmp_err, 1);
    chk("err_branch_count", branch_count, exp_b);
    chk("err_mis_count", mispredict_count, exp_m);

    // ---- randomized scoreboard run ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rand_rst_cmp_err", cmp_err, 0);
    exp_b = 0; exp_m = 0; exp_err = 1'b0;
    q.delete();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_cmp    = 2'($urandom_range(0, 3));
      in_pc     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      in_imm    = $urandom;
      in_pred_taken = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = (q.size() == 0) || out_ready;
      chk("rand_in_ready", in_ready, exp_rdy);
      chk("rand_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rand_taken", out_taken, q[0].taken);
        chk("rand_redirect", out_redirect_pc, q[0].redirect);
        chk("rand_mispredict", out_mispredict, q[0].mis);
      end
      hs = (q.size() != 0) && out_ready && !flush;
      if (hs) begin
        exp_b = sat_inc(exp_b, 65535);
        if (q[0].mis) exp_m = sat_inc(exp_m, 65535);
        void'(q.pop_front());
      end
      if (flush) q.delete();
      if (in_valid && exp_rdy && !flush) begin
        t = ref_taken(int'(in_op), int'(in_cmp));
        q.push_back('{t, ref_redirect(int'(in_op), in_pc, in_imm, t), t != in_pred_taken});
        if (in_cmp == 2'd3 && in_op != 3'd0 && in_op != 3'd7) exp_err = 1'b1;
      end
      tick();
      chk("rand_branch_count", branch_count, exp_b);
      chk("rand_mis_count", mispredict_count, exp_m);
      chk("rand_cmp_err", cmp_err, exp_err);
    end
    flush = 1'b0;

    // ---- asynchronous reset while a result is held ----
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 2'd0, 32'h0, 32'h1234_5678, 1'b0);
    tick();
    chk("ar_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_taken", out_taken, 0);
    chk("ar_redirect", out_redirect_pc, 0);
    chk("ar_mispredict", out_mispredict, 0);
    chk("ar_cmp_err", cmp_err, 0);
    chk("ar_branch_count", branch_count, 0);
    chk("ar_mis_count", mispredict_count, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    #1 chk("ar_in_ready", in_ready, 1);

    // ---- saturation on the 4-bit instance ----
    h = 0;
    s_in_valid = 1'b1;
    for (int k = 0; k < 22; k++) begin
      hs = s_out_valid;
      tick();
      if (hs) h++;
      chk("sat_branch_count", s_branch_count, (h > 15) ? 15 : h);
      chk("sat_mis_count", s_mispredict_count, (h > 15) ? 15 : h);
    end
    chk("sat_taken", s_out_taken, 1);
    chk("sat_redirect", s_out_redirect_pc, 32'h0000_0ABC);
    chk("sat_mispredict", s_out_mispredict, 1);
    chk("sat_cmp_err", s_cmp_err, 0);
    chk("sat_in_ready", s_in_ready, 1);
    s_in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
